// File: rtl/div_check.sv
// div_check: measures period and high time of a divided clock, sampled as
// data in the source clock domain, and flags deviations from N_EXP.
module div_check #(
  parameter int unsigned N_EXP    = 7,
  parameter int unsigned CW       = 16,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_in,
  input  logic          en,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_cnt,
  output logic          meas_valid,
  output logic          err,
  output logic          timeout,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  localparam int unsigned   GW      = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] NEXP_C  = CW'(N_EXP);
  localparam logic [CW-1:0] HLO_C   = CW'(N_EXP / 2);
  localparam logic [CW-1:0] HHI_C   = CW'((N_EXP + 1) / 2);
  // Timeout counter value on the TO-th consecutive cycle without a rise.
  localparam logic [CW-1:0] TO_LAST = CW'(4 * N_EXP - 1);
  localparam logic [GW-1:0] LOCK_C  = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_MEAS
  } state_t;

  state_t        state_q, state_d;
  logic          d_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] to_q, to_d;
  logic [GW-1:0] good_q, good_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          mv_q, mv_d;
  logic          err_q, err_d;
  logic          tof_q, tof_d;
  logic [7:0]    errc_q, errc_d;

  logic          rise;
  logic          to_fire;
  logic          meas_good;
  logic [7:0]    errc_inc;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] hcnt_inc;
  logic [GW-1:0] good_inc;

  assign rise      = clk_in & ~d_q;
  // A rise on the TO-th quiet cycle is a normal edge, so it masks the timeout.
  assign to_fire   = (to_q == TO_LAST) && !rise;
  assign meas_good = (cnt_q == NEXP_C) && ((hcnt_q == HLO_C) || (hcnt_q == HHI_C));
  assign errc_inc  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign hcnt_inc  = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
  assign good_inc  = (good_q == LOCK_C) ? good_q : good_q + 1'b1;

  // Next-state and measurement logic; en=0 overrides every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    to_d     = to_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    err_d    = 1'b0;
    tof_d    = tof_q;
    errc_d   = errc_q;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      to_d    = '0;
      good_d  = '0;
      tof_d   = 1'b0;
      errc_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SYNC;
          cnt_d   = '0;
          hcnt_d  = '0;
          to_d    = '0;
        end
        S_SYNC: begin
          if (rise) begin
            state_d = S_MEAS;
            cnt_d   = CW'(1);
            hcnt_d  = CW'(1);
            to_d    = '0;
            tof_d   = 1'b0;
          end else if (to_fire) begin
            err_d   = 1'b1;
            tof_d   = 1'b1;
            errc_d  = errc_inc;
            good_d  = '0;
            to_d    = '0;
          end else begin
            to_d    = to_q + 1'b1;
          end
        end
        S_MEAS: begin
          if (rise) begin
            period_d = cnt_q;
            high_d   = hcnt_q;
            mv_d     = 1'b1;
            cnt_d    = CW'(1);
            hcnt_d   = CW'(1);
            to_d     = '0;
            if (meas_good) begin
              good_d = good_inc;
            end else begin
              err_d  = 1'b1;
              errc_d = errc_inc;
              good_d = '0;
            end
          end else if (to_fire) begin
            state_d = S_SYNC;
            err_d   = 1'b1;
            tof_d   = 1'b1;
            errc_d  = errc_inc;
            good_d  = '0;
            to_d    = '0;
            cnt_d   = '0;
            hcnt_d  = '0;
          end else begin
            to_d  = to_q + 1'b1;
            cnt_d = cnt_inc;
            if (clk_in) begin
              hcnt_d = hcnt_inc;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      d_q      <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      to_q     <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      err_q    <= 1'b0;
      tof_q    <= 1'b0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      d_q      <= clk_in;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      to_q     <= to_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      err_q    <= err_d;
      tof_q    <= tof_d;
      errc_q   <= errc_d;
    end
  end

  assign period     = period_q;
  assign high_cnt   = high_q;
  assign meas_valid = mv_q;
  assign err        = err_q;
  assign timeout    = tof_q;
  assign locked     = (good_q == LOCK_C);
  assign err_cnt    = errc_q;

endmodule

// File: tb/tb_div_check.sv
// Bench for div_check: two instances (N_EXP=7 and N_EXP=8) share clk_in and
// rst_n; only one is enabled at a time. Expected measurements are queued when
// a period is driven and popped when meas_valid appears.
module tb_div_check;

  typedef struct {
    int h;
    int l;
    int p;
    int hc;
    int e;
    int lk;
    int ec;
  } row_t;

  typedef struct {
    int p;
    int hc;
    int e;
    int lk;
    int ec;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clk_in;
  logic        en7;
  logic        en8;
  logic [15:0] period7, high7, period8, high8;
  logic        mv7, err7, to7, lk7;
  logic        mv8, err8, to8, lk8;
  logic [7:0]  ec7, ec8;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q7[$];
  exp_t q8[$];
  exp_t pend;
  bit   pend_v = 1'b0;
  bit   sel8   = 1'b0;
  row_t tab7[13];
  row_t tab8[11];

  div_check #(.N_EXP(7), .CW(16), .LOCK_CNT(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en7),
    .period(period7), .high_cnt(high7), .meas_valid(mv7), .err(err7),
    .timeout(to7), .locked(lk7), .err_cnt(ec7)
  );

  div_check #(.N_EXP(8), .CW(16), .LOCK_CNT(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .clk_in(clk_in), .en(en8),
    .period(period8), .high_cnt(high8), .meas_valid(mv8), .err(err8),
    .timeout(to8), .locked(lk8), .err_cnt(ec8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int p, input int hc, input int e, input int lk, input int ec);
    exp_t r;
    r.p = p; r.hc = hc; r.e = e; r.lk = lk; r.ec = ec;
    return r;
  endfunction

  task automatic push_pend();
    if (pend_v) begin
      if (sel8) q8.push_back(pend);
      else      q7.push_back(pend);
    end
    pend_v = 1'b0;
  endtask

  // One divided-clock period; its measurement is reported at the next rise.
  task automatic drive(input int h, input int l, input exp_t e);
    push_pend();
    for (int i = 0; i < h; i++) begin
      clk_in = 1'b1;
      @(negedge clk);
    end
    for (int i = 0; i < l; i++) begin
      clk_in = 1'b0;
      @(negedge clk);
    end
    pend   = e;
    pend_v = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mv7) begin
      chk("dut7 sb nonempty at meas_valid", (q7.size() > 0) ? 1 : 0, 1);
      if (q7.size() > 0) begin
        exp_t x;
        x = q7.pop_front();
        chk("dut7 period",   int'(period7), x.p);
        chk("dut7 high_cnt", int'(high7),   x.hc);
        chk("dut7 err",      int'(err7),    x.e);
        chk("dut7 locked",   int'(lk7),     x.lk);
        chk("dut7 err_cnt",  int'(ec7),     x.ec);
      end
    end
  end

  always @(negedge clk) begin
    if (mv8) begin
      chk("dut8 sb nonempty at meas_valid", (q8.size() > 0) ? 1 : 0, 1);
      if (q8.size() > 0) begin
        exp_t x;
        x = q8.pop_front();
        chk("dut8 period",   int'(period8), x.p);
        chk("dut8 high_cnt", int'(high8),   x.hc);
        chk("dut8 err",      int'(err8),    x.e);
        chk("dut8 locked",   int'(lk8),     x.lk);
        chk("dut8 err_cnt",  int'(ec8),     x.ec);
      end
    end
  end

  task automatic chk_zero7(input string tag);
    chk({tag, " period"},     int'(period7), 0);
    chk({tag, " high_cnt"},   int'(high7),   0);
    chk({tag, " meas_valid"}, int'(mv7),     0);
    chk({tag, " err"},        int'(err7),    0);
    chk({tag, " timeout"},    int'(to7),     0);
    chk({tag, " locked"},     int'(lk7),     0);
    chk({tag, " err_cnt"},    int'(ec7),     0);
  endtask

  initial begin
    int ecnt;
    //            h  l  p  hc e lk ec
    tab7[0]  = '{3, 4, 7, 3, 0, 0, 0};
    tab7[1]  = '{4, 3, 7, 4, 0, 0, 0};
    tab7[2]  = '{3, 4, 7, 3, 0, 0, 0};
    tab7[3]  = '{4, 3, 7, 4, 0, 1, 0};
    tab7[4]  = '{4, 3, 7, 4, 0, 1, 0};
    tab7[5]  = '{3, 3, 6, 3, 1, 0, 1};
    tab7[6]  = '{4, 4, 8, 4, 1, 0, 2};
    tab7[7]  = '{5, 2, 7, 5, 1, 0, 3};
    tab7[8]  = '{2, 5, 7, 2, 1, 0, 4};
    tab7[9]  = '{4, 3, 7, 4, 0, 0, 4};
    tab7[10] = '{3, 4, 7, 3, 0, 0, 4};
    tab7[11] = '{4, 3, 7, 4, 0, 0, 4};
    tab7[12] = '{3, 4, 7, 3, 0, 1, 4};

    tab8[0]  = '{4, 4, 8, 4, 0, 0, 0};
    tab8[1]  = '{4, 4, 8, 4, 0, 0, 0};
    tab8[2]  = '{4, 4, 8, 4, 0, 0, 0};
    tab8[3]  = '{4, 4, 8, 4, 0, 1, 0};
    tab8[4]  = '{5, 3, 8, 5, 1, 0, 1};
    tab8[5]  = '{4, 4, 8, 4, 0, 0, 1};
    tab8[6]  = '{4, 4, 8, 4, 0, 0, 1};
    tab8[7]  = '{4, 4, 8, 4, 0, 0, 1};
    tab8[8]  = '{4, 4, 8, 4, 0, 1, 1};
    tab8[9]  = '{3, 5, 8, 3, 1, 0, 2};
    tab8[10] = '{4, 4, 8, 4, 0, 0, 2};

    rst_n  = 1'b0;
    clk_in = 1'b0;
    en7    = 1'b0;
    en8    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero7("reset");

    // Table-driven periods against N_EXP=7.
    rst_n = 1'b1;
    en7   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++)
      drive(tab7[i].h, tab7[i].l,
            mk(tab7[i].p, tab7[i].hc, tab7[i].e, tab7[i].lk, tab7[i].ec));

    // Rise closes the last table period, then clk_in stays low: TO=28.
    push_pend();
    clk_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 28) begin
        chk("to early err",     int'(err7), 0);
        chk("to early timeout", int'(to7),  0);
      end
      if (i == 29) begin
        chk("to err pulse", int'(err7), 1);
        chk("to timeout",   int'(to7),  1);
        chk("to locked",    int'(lk7),  0);
        chk("to err_cnt",   int'(ec7),  5);
      end
      if (i == 30) begin
        chk("to err one-shot",  int'(err7), 0);
        chk("to timeout stick", int'(to7),  1);
      end
      if (i == 4) clk_in = 1'b0;
    end

    // First rise after timeout restarts measurement with no meas_valid.
    drive(4, 3, mk(7, 4, 0, 0, 5));
    chk("timeout cleared", int'(to7), 0);

    // Bad periods until err_cnt saturates.
    ecnt = 5;
    for (int i = 0; i < 300; i++) begin
      ecnt = (ecnt < 255) ? ecnt + 1 : 255;
      drive(3, 3, mk(6, 3, 1, 0, ecnt));
    end
    chk("err_cnt saturated", int'(ec7), 255);

    // Disable clears status but holds the last measurement.
    en7    = 1'b0;
    pend_v = 1'b0;
    @(negedge clk);
    chk("dis err_cnt",  int'(ec7),     0);
    chk("dis locked",   int'(lk7),     0);
    chk("dis timeout",  int'(to7),     0);
    chk("dis period",   int'(period7), 6);
    chk("dis high_cnt", int'(high7),   3);

    // Reset in the middle of a period.
    en7 = 1'b1;
    @(negedge clk);
    drive(4, 3, mk(7, 4, 0, 0, 0));
    drive(4, 3, mk(7, 4, 0, 0, 0));
    push_pend();
    clk_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b0;
    clk_in = 1'b0;
    @(negedge clk);
    chk_zero7("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    drive(4, 3, mk(7, 4, 0, 0, 0));
    drive(4, 3, mk(7, 4, 0, 0, 0));
    pend_v = 1'b0;

    // Table-driven periods against N_EXP=8.
    en7  = 1'b0;
    sel8 = 1'b1;
    en8  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++)
      drive(tab8[i].h, tab8[i].l,
            mk(tab8[i].p, tab8[i].hc, tab8[i].e, tab8[i].lk, tab8[i].ec));
    pend_v = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("dut7 sb drained", q7.size(), 0);
    chk("dut8 sb drained", q8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_check.md
# div_check

Synchronous checker for the output of the odd/even clock dividers (`div_odd` and siblings). It samples the divided clock as a data signal in the source `clk` domain, measures period and high time in source-clock cycles, and compares them against the expected ratio. It reports per-period measurements, error pulses, a saturating error count and a lock flag for bring-up and self-test. It sits directly downstream of the divider, on the same `clk`.

## Interface
- `N_EXP`, default 7: expected division ratio (≥2, odd or even).
- `CW`, default 16: measurement counter width; must hold 4·N_EXP.
- `LOCK_CNT`, default 4: consecutive good periods required to assert `locked`.
- `clk`  in  1  source clock, the same clock that drives the divider; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `clk_in`  in  1  divider output, sampled as data; no synchroniser.
- `en`  in  1  monitor enable; 0 forces IDLE.
- `period`  out  CW  last measured rise-to-rise interval, in clk cycles.
- `high_cnt`  out  CW  number of posedge samples with `clk_in`=1 in the last period.
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_cnt` update.
- `err`  out  1  one-cycle pulse on a bad measurement or timeout.
- `timeout`  out  1  sticky: no rising edge seen for TO=4·N_EXP cycles; cleared by the next rise.
- `locked`  out  1  LOCK_CNT consecutive good measurements seen.
- `err_cnt`  out  8  error count, saturates at 255.

## Operation
- Edge detect: `d_q` <= `clk_in` each cycle; `rise` = `clk_in` & ~`d_q`.
- States:
  - IDLE: entered on reset or when `en`=0.
  - IDLE→SYNC when `en`=1.
  - SYNC→MEAS on the first `rise`. This rise loads `cnt`=1 and `hcnt`=1. No `meas_valid` is produced for it.
- In MEAS, on cycles where `rise`=0:
  - `cnt` increments.
  - `hcnt` increments when `clk_in`=1.
- In MEAS, on a cycle where `rise`=1:
  - `period` <= `cnt`, `high_cnt` <= `hcnt`, `meas_valid` <= 1.
  - Then `cnt` <= 1 and `hcnt` <= 1.
- A measurement is good iff both hold:
  - `cnt`==N_EXP.
  - `hcnt` ∈ {floor(N_EXP/2), ceil(N_EXP/2)}. Both values are accepted because odd dividers have a half-cycle edge.
- Bad measurement: `err` pulses in the same cycle as `meas_valid`, `err_cnt` increments, and the good-run counter clears.
- Good measurement: the good-run counter increments, saturating at LOCK_CNT.
- `locked` is 1 while the good-run counter equals LOCK_CNT. It clears on any error (bad measurement or timeout) and on `en`=0.
- Timeout: in SYNC or MEAS, if TO consecutive cycles pass with no `rise`:
  - `err` pulses, `timeout` is set, `err_cnt` increments, `locked` clears.
  - The state goes to SYNC and the timeout counter restarts.
  - The next `rise` clears `timeout` and, as in SYNC, starts a new measurement with no `meas_valid`.
- `en`=0, taking effect at the next posedge:
  - State goes to IDLE. Internal counters clear; `locked`, `timeout` and `err_cnt` clear.
  - `period` and `high_cnt` hold their last values.
- `err_cnt` saturates at 255.
- `cnt` and `hcnt` saturate at 2^CW−1; the timeout fires first when CW is sized correctly.

## Timing
- Reset values (at the posedge with `rst_n`=0): all outputs 0, state IDLE, `d_q`=0, all counters 0.
- Latency: `meas_valid`, `err`, `period` and `high_cnt` appear one cycle after the posedge at which `rise` is first true.
- For a steady divider with ratio N, `meas_valid` pulses exactly every N cycles.
- Priority:
  - A `rise` in the same cycle the timeout count reaches TO wins: it is a normal measurement, not a timeout.
  - `en`=0 overrides everything except reset.
- Reset mid-measurement: all state is discarded, with no `meas_valid` and no `err` in that cycle.
- `locked` rises in the same cycle as the LOCK_CNT-th good `meas_valid`.

## Test plan
- Drive `clk_in` from `div_odd` #(N=7); `rst_n` low for 1 cycle, then `en`=1.
  - First `meas_valid` comes one period after the first rise.
  - Every 7 cycles: `period`=7, `high_cnt` ∈ {3,4}, `err`=0.
  - `locked`=1 at the 4th `meas_valid`.
- Bench pattern with N_EXP=8: high 4 / low 4.
  - `period`=8, `high_cnt`=4, no `err`.
  - Then high 5 / low 3: `err` pulses with `meas_valid`, `err_cnt`=1, `locked`=0.
  - Four more good periods: `locked`=1 again.
- Hold `clk_in`=0 after lock (N_EXP=7).
  - 28 cycles after the last rise: `err` pulse, `timeout`=1, `locked`=0, `err_cnt`+1.
  - On the next rise: `timeout`=0, and no `meas_valid` until the rise after.
- Period of 6 and of 8 with N_EXP=7: `period` reads 6 and 8, and each gives an `err` pulse.
- Saturation and clear:
  - 300 bad periods: `err_cnt` sticks at 255.
  - Drop `en` to 0: `err_cnt`, `locked` and `timeout` read 0 next cycle; `period` holds.
- Assert `rst_n`=0 mid-period: next cycle all outputs are 0. After release, the first `meas_valid` needs two rises.
